// File: rtl/cdb_broadcaster_pkg.sv
// Shared defaults and types for the CDB broadcaster slice.
// Optional feature macro: CDB_BYPASS_EN (empty-slot bypass to the CDB).
package cdb_broadcaster_pkg;

   localparam int DEF_DATA_WIDTH    = 4;
   localparam int DEF_CDB_TAG_WIDTH = 4;
   localparam int DEF_NUM_SOURCES   = 2;

   // Where the winning result comes from this cycle.
   typedef enum logic {
      SEL_SLOT   = 1'b0,
      SEL_BYPASS = 1'b1
   } sel_e;

   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr wins.
// Produces a one-hot grant and the pointer value following the winner.
module rr_arbiter
   import cdb_broadcaster_pkg::*;
#(
   parameter int N  = 2,
   parameter int PW = ptr_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] next_ptr
);

   int   idx;
   logic found;

   always_comb begin
      grant    = '0;
      next_ptr = ptr;
      found    = 1'b0;
      idx      = 0;
      for (int j = 0; j < N; j++) begin
         idx = (int'(ptr) + j) % N;
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            next_ptr   = (idx == N - 1) ? '0 : PW'(idx + 1);
         end
      end
   end

endmodule

// File: rtl/cdb_broadcaster.sv
// Producer end of the CDB: one holding slot per source, RR pick, registered bus.
// Define CDB_BYPASS_EN to let an offer skip its empty slot when no slot is full.
module cdb_broadcaster
   import cdb_broadcaster_pkg::*;
#(
   parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int CDB_TAG_WIDTH = DEF_CDB_TAG_WIDTH,
   parameter int NUM_SOURCES   = DEF_NUM_SOURCES
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [NUM_SOURCES-1:0]                 src_valid,
   input  logic [NUM_SOURCES*CDB_TAG_WIDTH-1:0]   src_tag,
   input  logic [NUM_SOURCES*DATA_WIDTH-1:0]      src_data,
   output logic [NUM_SOURCES-1:0]                 src_ready,
   output logic                                   cdb_out_valid,
   output logic [CDB_TAG_WIDTH-1:0]               cdb_out_tag,
   output logic [DATA_WIDTH-1:0]                  cdb_out_data
);

   localparam int PW = ptr_width(NUM_SOURCES);

   logic [NUM_SOURCES-1:0]   full;
   logic [NUM_SOURCES-1:0]   req;
   logic [NUM_SOURCES-1:0]   grant;
   logic [CDB_TAG_WIDTH-1:0] tag_q  [NUM_SOURCES];
   logic [DATA_WIDTH-1:0]    data_q [NUM_SOURCES];
   logic [PW-1:0]            ptr;
   logic [PW-1:0]            next_ptr;
   logic [CDB_TAG_WIDTH-1:0] win_tag;
   logic [DATA_WIDTH-1:0]    win_data;
   sel_e                     sel;

`ifdef CDB_BYPASS_EN
   assign sel = (full == '0) ? SEL_BYPASS : SEL_SLOT;
`else
   assign sel = SEL_SLOT;
`endif

   // Full slots always win; raw offers only compete when nothing is buffered.
   assign req = (sel == SEL_BYPASS) ? src_valid : full;

   rr_arbiter #(
      .N  (NUM_SOURCES),
      .PW (PW)
   ) u_arb (
      .req      (req),
      .ptr      (ptr),
      .grant    (grant),
      .next_ptr (next_ptr)
   );

   assign src_ready = rst ? '0 : (~full | grant);

   always_comb begin
      win_tag  = '0;
      win_data = '0;
      for (int i = 0; i < NUM_SOURCES; i++) begin
         if (grant[i]) begin
            if (sel == SEL_BYPASS) begin
               win_tag  = src_tag[i*CDB_TAG_WIDTH +: CDB_TAG_WIDTH];
               win_data = src_data[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
               win_tag  = tag_q[i];
               win_data = data_q[i];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full <= '0;
         for (int i = 0; i < NUM_SOURCES; i++) begin
            tag_q[i]  <= '0;
            data_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_SOURCES; i++) begin
            // A bypassed offer goes straight to the bus, never into its slot.
            if (src_valid[i] && src_ready[i] &&
                !(sel == SEL_BYPASS && grant[i])) begin
               full[i]   <= 1'b1;
               tag_q[i]  <= src_tag[i*CDB_TAG_WIDTH +: CDB_TAG_WIDTH];
               data_q[i] <= src_data[i*DATA_WIDTH +: DATA_WIDTH];
            end else if (grant[i]) begin
               full[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr           <= '0;
         cdb_out_valid <= 1'b0;
         cdb_out_tag   <= '0;
         cdb_out_data  <= '0;
      end else begin
         ptr <= next_ptr;
         if (grant != '0) begin
            cdb_out_valid <= 1'b1;
            cdb_out_tag   <= win_tag;
            cdb_out_data  <= win_data;
         end else begin
            cdb_out_valid <= 1'b0;
         end
      end
   end

   a_grant_onehot: assert property (
      @(posedge clk) disable iff (rst) $onehot0(grant)
   );

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Directed self-checking bench for cdb_broadcaster.
// Honours CDB_BYPASS_EN for the expected latency and handshake vectors.
module tb_cdb_broadcaster;

   localparam int DW = 4;
   localparam int TW = 4;
   localparam int N  = 2;
`ifdef CDB_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    src_valid = '0;
   logic [N*TW-1:0] src_tag = '0;
   logic [N*DW-1:0] src_data = '0;
   logic [N-1:0]    src_ready;
   logic            cdb_out_valid;
   logic [TW-1:0]   cdb_out_tag;
   logic [DW-1:0]   cdb_out_data;

   int checks = 0;
   int errors = 0;

   cdb_broadcaster #(
      .DATA_WIDTH    (DW),
      .CDB_TAG_WIDTH (TW),
      .NUM_SOURCES   (N)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .src_valid     (src_valid),
      .src_tag       (src_tag),
      .src_data      (src_data),
      .src_ready     (src_ready),
      .cdb_out_valid (cdb_out_valid),
      .cdb_out_tag   (cdb_out_tag),
      .cdb_out_data  (cdb_out_data)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input int i, input logic v,
                          input logic [TW-1:0] t, input logic [DW-1:0] d);
      src_valid[i]          = v;
      src_tag[i*TW +: TW]   = t;
      src_data[i*DW +: DW]  = d;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      src_valid = '0;
      src_tag   = '0;
      src_data  = '0;
      step();
      step();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      step();
      checks++;
      if (cdb_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_valid: got %b want 0", cdb_out_valid);
      end
      checks++;
      if (cdb_out_tag !== '0 || cdb_out_data !== '0) begin
         errors++;
         $display("FAIL rst_bus: got %h/%h want 0/0", cdb_out_tag, cdb_out_data);
      end
      checks++;
      if (src_ready !== 2'b00) begin
         errors++;
         $display("FAIL rst_ready: got %b want 00", src_ready);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (src_ready !== 2'b11) begin
         errors++;
         $display("FAIL post_rst_ready: got %b want 11", src_ready);
      end
      set_src(0, 1'b1, 4'd1, 4'd5);
      set_src(1, 1'b1, 4'd8, 4'd6);
      step();
      src_valid = '0;
      for (int k = 1; k < LAT; k++) step();
      checks++;
      if (cdb_out_valid !== 1'b1 || cdb_out_tag !== 4'd1) begin
         errors++;
         $display("FAIL midrun_bcast: got %b/%h want 1/1",
                  cdb_out_valid, cdb_out_tag);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({cdb_out_valid, cdb_out_tag, cdb_out_data} !== '0) begin
         errors++;
         $display("FAIL async_rst: got %b/%h/%h want 0/0/0",
                  cdb_out_valid, cdb_out_tag, cdb_out_data);
      end
      checks++;
      if (src_ready !== 2'b00) begin
         errors++;
         $display("FAIL async_rst_ready: got %b want 00", src_ready);
      end
      step();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         checks++;
         if (cdb_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_discard c%0d: got %b want 0", k, cdb_out_valid);
         end
      end
   endtask

   task automatic test_single();
      do_reset();
      set_src(0, 1'b1, 4'd3, 4'hA);
      set_src(1, 1'b0, 4'd0, 4'd0);
      checks++;
      if (src_ready[0] !== 1'b1) begin
         errors++;
         $display("FAIL single_ready: got %b want 1", src_ready[0]);
      end
      step();
      src_valid = '0;
      for (int k = 1; k <= LAT + 1; k++) begin
         checks++;
         if (cdb_out_valid !== (k == LAT)) begin
            errors++;
            $display("FAIL single_valid c%0d: got %b want %b",
                     k, cdb_out_valid, (k == LAT));
         end
         if (k >= LAT) begin
            checks++;
            if (cdb_out_tag !== 4'd3 || cdb_out_data !== 4'hA) begin
               errors++;
               $display("FAIL single_bus c%0d: got %h/%h want 3/a",
                        k, cdb_out_tag, cdb_out_data);
            end
         end
         step();
      end
   endtask

   task automatic test_contention();
      logic exp_v;
      logic [TW-1:0] exp_t;
      do_reset();
      for (int r = 0; r < 2; r++) begin
         set_src(0, 1'b1, 4'd1, 4'd1);
         set_src(1, 1'b1, 4'd2, 4'd2);
         step();
         src_valid = '0;
         for (int k = 1; k <= LAT + 2; k++) begin
            exp_v = (k == LAT) || (k == LAT + 1);
            exp_t = (k == LAT) ? 4'd1 : 4'd2;
            checks++;
            if (cdb_out_valid !== exp_v ||
                (exp_v && cdb_out_tag !== exp_t)) begin
               errors++;
               $display("FAIL contention r%0d c%0d: got %b/%h want %b/%h",
                        r, k, cdb_out_valid, cdb_out_tag, exp_v, exp_t);
            end
            step();
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [TW-1:0] exp_out [6];
      logic [N-1:0]  exp_rdy [7];
      logic [N-1:0]  hs;
      int cnt0;
      int cnt1;
      exp_out = '{4'd1, 4'd8, 4'd2, 4'd9, 4'd3, 4'd10};
`ifdef CDB_BYPASS_EN
      exp_rdy = '{2'b11, 2'b11, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
`else
      exp_rdy = '{2'b11, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`endif
      cnt0 = 0;
      cnt1 = 0;
      do_reset();
      for (int c = 0; c < 8; c++) begin
         if (c >= LAT && c - LAT < 6) begin
            checks++;
            if (cdb_out_valid !== 1'b1 || cdb_out_tag !== exp_out[c-LAT]) begin
               errors++;
               $display("FAIL b2b_bcast c%0d: got %b/%h want 1/%h",
                        c, cdb_out_valid, cdb_out_tag, exp_out[c-LAT]);
            end
         end
         set_src(0, 1'b1, 4'(1 + cnt0), 4'(1 + cnt0));
         set_src(1, 1'b1, 4'(8 + cnt1), 4'(8 + cnt1));
         if (c <= 6) begin
            checks++;
            if (src_ready !== exp_rdy[c]) begin
               errors++;
               $display("FAIL b2b_ready c%0d: got %b want %b",
                        c, src_ready, exp_rdy[c]);
            end
         end
         hs = src_valid & src_ready;
         step();
         cnt0 += int'(hs[0]);
         cnt1 += int'(hs[1]);
      end
      src_valid = '0;
   endtask

   task automatic test_drain_refill();
      int hits;
      do_reset();
      set_src(0, 1'b1, 4'd4, 4'd4);
      set_src(1, 1'b0, 4'd0, 4'd0);
      step();
      set_src(0, 1'b1, 4'd5, 4'd5);
      checks++;
      if (src_ready[0] !== 1'b1) begin
         errors++;
         $display("FAIL refill_ready: got %b want 1", src_ready[0]);
      end
      step();
      src_valid = '0;
      hits = 0;
      for (int k = 0; k <= N; k++) begin
         if (cdb_out_valid && cdb_out_tag == 4'd5) hits++;
         step();
      end
      checks++;
      if (hits !== 1) begin
         errors++;
         $display("FAIL refill_bcast: got %0d broadcasts of tag 5 want 1", hits);
      end
   endtask

   task automatic test_stream();
      logic [15:0]  lfsr;
      logic [N-1:0] hs;
      int seq [N];
      int exp_seq [N];
      int acc;
      int bc;
      int s;
      int q;
      lfsr = 16'hACE1;
      acc  = 0;
      bc   = 0;
      for (int i = 0; i < N; i++) begin
         seq[i]     = 0;
         exp_seq[i] = 0;
      end
      do_reset();
      for (int c = 0; c < 212; c++) begin
         if (cdb_out_valid) begin
            s = int'(cdb_out_tag[3]);
            q = int'(cdb_out_tag[2:0]);
            checks++;
            if (q != exp_seq[s] % 8 || cdb_out_data !== cdb_out_tag) begin
               errors++;
               $display("FAIL stream_order src%0d: got seq %0d data %h want seq %0d",
                        s, q, cdb_out_data, exp_seq[s] % 8);
            end
            exp_seq[s]++;
            bc++;
         end
         for (int i = 0; i < N; i++) begin
            set_src(i, (c < 200) ? lfsr[i] : 1'b0,
                    4'(i * 8 + seq[i] % 8), 4'(i * 8 + seq[i] % 8));
         end
         hs = src_valid & src_ready;
         step();
         for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
               seq[i]++;
               acc++;
            end
         end
         lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      end
      checks++;
      if (acc !== bc) begin
         errors++;
         $display("FAIL stream_count: got %0d broadcasts want %0d", bc, acc);
      end
      checks++;
      if (acc < 50) begin
         errors++;
         $display("FAIL stream_accepted: got %0d want at least 50", acc);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_back_to_back();
      test_drain_refill();
      test_stream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
